sha_1_arbiter: RTL and testbench

SHA_1_ARBITER -- requirements
Module: sha_1_arbiter

---
 rtl/sha_1_arbiter.sv | 136 +++++++++++++
 tb/tb_sha_1_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sha_1_arbiter.sv
// sha_1_arbiter: two-requester round-robin front end for a SHA-1 accelerator.
// Define SHA1_ARB_TIMEOUT_EN to abort jobs that stay in WAIT for TIMEOUT_CYCLES cycles.
module sha_1_arbiter #(
   parameter int START_HOLD     = 4,
   parameter int START_GAP      = 3,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [1:0]   req,
   input  logic [511:0] req_data0,
   input  logic [511:0] req_data1,
   output logic [1:0]   gnt,
   output logic [1:0]   rsp_valid,
   output logic [159:0] rsp_data,
   output logic         rsp_err,
   output logic         acc_start,
   output logic [511:0] acc_in_data,
   input  logic         acc_done,
   input  logic [159:0] acc_out_data,
   output logic         busy,
   output logic         owner
);

   typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, RESP, COOL} state_t;

   state_t         state_q, state_d;
   logic [1:0]     gnt_q, gnt_d, rv_q, rv_d;
   logic           start_q, start_d, owner_q, owner_d, last_q, last_d;
   logic [159:0]   data_q, data_d;
   logic [511:0]   in_q, in_d;
   logic [3:0]     cnt_q, cnt_d;
   logic           win, hold_end, gap_end, expire;

   assign hold_end = cnt_q == 4'(START_HOLD - 1);
   assign gap_end  = cnt_q == 4'(START_GAP - 1);

`ifdef SHA1_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_q, tmo_d;
   logic          err_q, err_d;
   assign expire = tmo_q == TW'(TIMEOUT_CYCLES);
   always_comb begin
      tmo_d = (state_q == WAIT && !acc_done && !expire) ? tmo_q + TW'(1) : '0;
      err_d = (state_q == WAIT && (acc_done || expire)) ? !acc_done : err_q;
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= tmo_d;
         err_q <= err_d;
      end
   end
   assign rsp_err = err_q;
`else
   assign expire  = 1'b0;
   assign rsp_err = TIMEOUT_CYCLES < 0;
`endif

   always_comb begin
      win     = &req ? ~last_q : req[1];
      state_d = state_q;
      gnt_d   = 2'b00;
      rv_d    = 2'b00;
      start_d = start_q;
      owner_d = owner_q;
      last_d  = last_q;
      data_d  = data_q;
      in_d    = in_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (|req) begin
            state_d = LAUNCH;
            gnt_d   = win ? 2'b10 : 2'b01;
            owner_d = win;
            in_d    = win ? req_data1 : req_data0;
            start_d = 1'b1;
         end
         LAUNCH: begin
            cnt_d   = hold_end ? 4'd0 : cnt_q + 4'd1;
            state_d = hold_end ? WAIT : LAUNCH;
            start_d = !hold_end;
         end
         // acc_done wins over a timeout landing on the same cycle
         WAIT: if (acc_done || expire) begin
            state_d = RESP;
            rv_d    = owner_q ? 2'b10 : 2'b01;
            data_d  = acc_done ? acc_out_data : data_q;
         end
         RESP: begin
            state_d = COOL;
            last_d  = owner_q;
         end
         COOL: begin
            cnt_d   = gap_end ? 4'd0 : cnt_q + 4'd1;
            state_d = gap_end ? IDLE : COOL;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         gnt_q   <= 2'b00;
         rv_q    <= 2'b00;
         start_q <= 1'b0;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         data_q  <= '0;
         in_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         rv_q    <= rv_d;
         start_q <= start_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         data_q  <= data_d;
         in_q    <= in_d;
         cnt_q   <= cnt_d;
      end
   end

   assign gnt         = gnt_q;
   assign rsp_valid   = rv_q;
   assign rsp_data    = data_q;
   assign acc_start   = start_q;
   assign acc_in_data = in_q;
   assign busy        = state_q != IDLE;
   assign owner       = owner_q;

endmodule

// File: tb/tb_sha_1_arbiter.sv
// tb_sha_1_arbiter: randomized and directed checks of sha_1_arbiter against a job-timeline model;
// the bench stands in for the accelerator.
module tb_sha_1_arbiter;
   localparam int H = 4, G = 3, T = 20;
`ifdef SHA1_ARB_TIMEOUT_EN
   localparam bit TMO = 1'b1;
`else
   localparam bit TMO = 1'b0;
`endif

   logic         clk = 1'b0, reset_n = 1'b0, acc_done = 1'b0;
   logic [1:0]   req = 2'b00;
   logic [511:0] req_data0 = '0, req_data1 = '0;
   logic [159:0] acc_out_data = '0;
   logic [1:0]   gnt, rsp_valid;
   logic [159:0] rsp_data;
   logic         rsp_err, acc_start, busy, owner;
   logic [511:0] acc_in_data;

   always #5 clk = ~clk;

   sha_1_arbiter #(.START_HOLD(H), .START_GAP(G), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .req_data0(req_data0), .req_data1(req_data1),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .acc_start(acc_start), .acc_in_data(acc_in_data), .acc_done(acc_done),
      .acc_out_data(acc_out_data), .busy(busy), .owner(owner)
   );

   int n_chk = 0, n_err = 0, cyc = 0;
   bit chk_on = 1'b0;
   // Model: a job is a timeline anchored at its grant cycle m_g and response cycle m_r.
   bit m_act = 1'b0, m_own = 1'b0, m_last = 1'b1, m_err = 1'b0;
   int m_g = -100, m_r = -1;
   logic [511:0] m_in = '0;
   logic [159:0] m_data = '0;

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_step();
      bit w;
      if (!reset_n) begin
         m_act = 1'b0; m_own = 1'b0; m_last = 1'b1; m_err = 1'b0; m_data = '0; m_in = '0;
      end else if (!m_act) begin
         if (req != 2'b00) begin
            w = (req == 2'b11) ? !m_last : req[1];
            m_act = 1'b1; m_g = cyc + 1; m_r = -1; m_own = w;
            m_in = w ? req_data1 : req_data0;
         end
      end else if (m_r < 0) begin
         if (cyc >= m_g + H) begin
            if (acc_done) begin
               m_r = cyc + 1; m_data = acc_out_data; m_err = 1'b0;
            end else if (TMO && cyc == m_g + H + T) begin
               m_r = cyc + 1; m_err = 1'b1;
            end
         end
      end else begin
         if (cyc == m_r) m_last = m_own;
         if (cyc == m_r + G) m_act = 1'b0;
      end
      cyc++;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic rnd512(output logic [511:0] v);
      for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom;
   endtask

   task automatic wait_gnt(output int n);
      n = 0;
      while (gnt == 2'b00 && n < 50) begin
         tick();
         n++;
      end
      if (gnt == 2'b00) begin
         n_chk++;
         n_err++;
         $display("FAIL gnt_timeout: no gnt within %0d cycles", n);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk("gnt", gnt, (m_act && cyc == m_g) ? (m_own ? 2'b10 : 2'b01) : 2'b00);
         chk("rsp_valid", rsp_valid, (m_act && m_r >= 0 && cyc == m_r) ? (m_own ? 2'b10 : 2'b01) : 2'b00);
         chk("acc_start", acc_start, m_act && cyc < m_g + H);
         chk("busy", busy, m_act);
         chk("owner", owner, m_own);
         chk("acc_in_data", acc_in_data, m_in);
         chk("rsp_data", rsp_data, m_data);
         if (m_act && m_r >= 0 && cyc == m_r) chk("rsp_err", rsp_err, m_err);
      end
   end

   initial begin
      logic [511:0] abc, d1, d;
      logic [159:0] dig;
      logic [1:0]   ord [4];
      bit           pend [2];
      int           n;
      abc = '0;
      abc[31:0] = 32'h61626380;
      abc[511:480] = 32'h00000018;
      dig = {32'h9CD0D89D, 32'h7850C26C, 32'hBA3E2571, 32'h4706816A, 32'hA9993E36};
      ord = '{2'b01, 2'b10, 2'b01, 2'b10};
      pend = '{1'b0, 1'b0};
      tick();
      chk_on = 1'b1;
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_gnt", gnt, 0);
      chk("rst_owner", owner, 0);
      chk("rst_start", acc_start, 0);
      chk("rst_data", rsp_data, 0);
      chk("rst_in", acc_in_data, 0);
      // single "abc" job with a stray acc_done during LAUNCH
      reset_n = 1'b1; req = 2'b01; req_data0 = abc;
      tick();
      chk("abc_gnt", gnt, 2'b01);
      chk("abc_in", acc_in_data, abc);
      chk("abc_start", acc_start, 1);
      req = 2'b00; acc_done = 1'b1; acc_out_data = ~dig;
      tick();
      acc_done = 1'b0;
      tick();
      tick();
      chk("hold4", acc_start, 1);
      tick();
      chk("wait_start", acc_start, 0);
      chk("stray_done", rsp_data, 0);
      acc_done = 1'b1; acc_out_data = dig;
      tick();
      acc_done = 1'b0; acc_out_data = '0;
      chk("abc_valid", rsp_valid, 2'b01);
      chk("abc_digest", rsp_data, dig);
      chk("abc_err", rsp_err, 0);
      tick();
      chk("valid_pulse", rsp_valid, 0);
      chk("cool_busy", busy, 1);
      // requester 1 arrives while requester 0 waits
      req = 2'b01;
      wait_gnt(n);
      req = 2'b00;
      repeat (H) tick();
      req = 2'b10; rnd512(d1); req_data1 = d1;
      tick();
      acc_done = 1'b1;
      tick();
      acc_done = 1'b0;
      chk("r0_valid", rsp_valid, 2'b01);
      wait_gnt(n);
      chk("pend_latency", n, 5);
      chk("pend_gnt", gnt, 2'b10);
      chk("pend_in", acc_in_data, d1);
      req = 2'b00;
      // reset while in WAIT
      repeat (H) tick();
      reset_n = 1'b0;
      tick();
      chk("wrst_busy", busy, 0);
      chk("wrst_valid", rsp_valid, 0);
      chk("wrst_data", rsp_data, 0);
      chk("wrst_owner", owner, 0);
      reset_n = 1'b1; req = 2'b11; req_data0 = abc; req_data1 = d1;
      for (int j = 0; j < 4; j++) begin
         wait_gnt(n);
         chk("rr_order", gnt, ord[j]);
         if (j > 0) chk("rr_gap", n + 1, 6);
         repeat (H) tick();
         acc_done = 1'b1; acc_out_data = dig;
         tick();
         acc_done = 1'b0;
         chk("rr_digest", rsp_data, dig);
      end
      req = 2'b00;
`ifdef SHA1_ARB_TIMEOUT_EN
      req = 2'b01;
      wait_gnt(n);
      req = 2'b00;
      repeat (H) tick();
      n = 0;
      while (rsp_valid == 2'b00 && n < 60) begin
         tick();
         n++;
      end
      chk("tmo_latency", n, 21);
      chk("tmo_valid", rsp_valid, 2'b01);
      chk("tmo_err", rsp_err, 1);
      chk("tmo_data", rsp_data, dig);
`endif
      for (int c = 0; c < 3000; c++) begin
         reset_n = $urandom_range(0, 149) != 0;
         for (int i = 0; i < 2; i++) begin
            if (pend[i] && gnt[i]) pend[i] = 1'b0;
            if (!pend[i] && $urandom_range(0, 3) == 0) begin
               pend[i] = 1'b1;
               rnd512(d);
               if (i == 0) req_data0 = d;
               else req_data1 = d;
            end
         end
         req = {pend[1], pend[0]};
         acc_done = $urandom_range(0, 7) == 0;
         acc_out_data = {$urandom, $urandom, $urandom, $urandom, $urandom};
         tick();
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
